// File: rtl/cordic_arbiter.sv
// Round-robin arbiter sharing one cordic engine between N_REQ requesters.
// Each grant latches the winner's angle and pulses start to the engine. When
// the engine's done handshake completes, the x/y result is returned tagged
// with the requester index. Every output is driven from a register.

module cordic_arbiter #(
    parameter int BIT_WIDTH   = 8,
    parameter int N_REQ       = 4,
    parameter int LOG_2_N_REQ = 2
) (
    input  logic                         clk,
    input  logic                         reset,

    // requester side
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ*BIT_WIDTH-1:0]   req_angle,
    output logic [N_REQ-1:0]             ack,
    output logic                         rsp_valid,
    output logic [LOG_2_N_REQ-1:0]       rsp_id,
    output logic [BIT_WIDTH-1:0]         rsp_x,
    output logic [BIT_WIDTH-1:0]         rsp_y,
    output logic                         busy,

    // engine side
    output logic                         cordic_start,
    output logic [BIT_WIDTH-1:0]         cordic_angle,
    input  logic [BIT_WIDTH-1:0]         cordic_x,
    input  logic [BIT_WIDTH-1:0]         cordic_y,
    input  logic                         cordic_done
);

    typedef enum logic [1:0] {
        IDLE,       // engine free, waiting for a request
        WAIT_ACK,   // start issued, waiting for the engine to drop done
        WAIT_DONE   // engine running, waiting for done to return
    } state_t;

    state_t                   state;
    logic [LOG_2_N_REQ-1:0]   ptr;        // first index searched on the next grant
    logic [LOG_2_N_REQ-1:0]   id_q;       // requester owning the job in flight

    logic                     grant_found;
    logic [LOG_2_N_REQ-1:0]   grant_id;
    logic [LOG_2_N_REQ-1:0]   search_idx;
    logic [N_REQ-1:0]         grant_onehot;
    logic [BIT_WIDTH-1:0]     grant_angle;

    // Round-robin search: first set req bit at or above ptr, wrapping N_REQ-1 -> 0.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write so
        // no path leaves it unassigned; otherwise synthesis infers a latch.
        grant_found  = 1'b0;
        grant_id     = '0;
        search_idx   = '0;
        grant_onehot = '0;
        grant_angle  = '0;

        // The modulo keeps the wrap correct when N_REQ is not a power of two.
        for (int i = 0; i < N_REQ; i++) begin
            search_idx = LOG_2_N_REQ'((int'(ptr) + i) % N_REQ);
            if (!grant_found && req[search_idx]) begin
                grant_found = 1'b1;
                grant_id    = search_idx;
            end
        end

        for (int i = 0; i < N_REQ; i++) begin
            grant_onehot[i] = grant_found && (grant_id == LOG_2_N_REQ'(i));
        end

        grant_angle = req_angle[grant_id*BIT_WIDTH +: BIT_WIDTH];
    end

    // Control FSM with registered outputs; ack, cordic_start and rsp_valid are single-cycle pulses.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is only acted on at a clock edge;
        // a reset during a job abandons it without any ack or rsp.
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            id_q         <= '0;
            ack          <= '0;
            cordic_start <= 1'b0;
            cordic_angle <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_x        <= '0;
            rsp_y        <= '0;
            busy         <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values, regardless of statement order.
            ack          <= '0;
            cordic_start <= 1'b0;
            rsp_valid    <= 1'b0;

            case (state)
                IDLE: begin
                    // Only grant when the engine reports idle; otherwise requests wait.
                    if (cordic_done && grant_found) begin
                        id_q         <= grant_id;
                        cordic_angle <= grant_angle;
                        ack          <= grant_onehot;
                        cordic_start <= 1'b1;
                        ptr          <= (grant_id == LOG_2_N_REQ'(N_REQ - 1))
                                        ? '0 : grant_id + 1'b1;
                        state        <= WAIT_ACK;
                        busy         <= 1'b1;
                    end
                end

                WAIT_ACK: begin
                    // Engine latency is unbounded; wait for it to leave idle.
                    if (!cordic_done) begin
                        state <= WAIT_DONE;
                    end
                end

                WAIT_DONE: begin
                    if (cordic_done) begin
                        rsp_x     <= cordic_x;
                        rsp_y     <= cordic_y;
                        rsp_id    <= id_q;
                        rsp_valid <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
